// File: rtl/qracc_bitserial_seq.sv
// Bit-serial MAC sequencer: drives activation bit planes onto ternary row lines and
// shift-accumulates per-column ADC codes. Optional zero-plane skipping: QRACC_PLANE_SKIP_EN.
module qracc_bitserial_seq #(
    parameter int unsigned numRows      = 128,
    parameter int unsigned numCols      = 8,
    parameter int unsigned xBits        = 4,
    parameter int unsigned numAdcBits   = 4,
    parameter int unsigned settleCycles = 2,
    parameter int unsigned accBits      = numAdcBits + xBits + 1
) (
    input  logic                          clk,
    input  logic                          nrst,
    input  logic [$clog2(xBits):0]        cfg_n_bits_i,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [numRows*xBits-1:0]      in_data_i,
    output logic                          mac_en_o,
    output logic [numRows-1:0]            data_p_o,
    output logic [numRows-1:0]            data_n_o,
    input  logic [numCols*numAdcBits-1:0] adc_out_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [numCols*accBits-1:0]    out_data_o,
    output logic                          busy_o
);
    localparam int unsigned NB  = $clog2(xBits) + 1;
    localparam int unsigned CW  = (settleCycles > 1) ? $clog2(settleCycles) : 1;
    localparam int unsigned DW  = numAdcBits + 1;
    localparam int unsigned MID = 1 << (numAdcBits - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_DRIVE, ST_DONE} state_t;

    state_t                     r_state, w_state_nxt;
    logic [numRows*xBits-1:0]   r_x, w_x_nxt;
    logic [NB-1:0]              r_n, w_n_nxt, w_n_cfg;
    logic [NB-1:0]              r_plane, w_plane_nxt;
    logic [CW-1:0]              r_cnt, w_cnt_nxt;
    logic                       r_empty, w_empty_nxt;
    logic                       w_clear, w_sample;
    logic [xBits-1:0]           w_nz_in, w_nz_x;
    logic [NB:0]                w_first, w_next;
    logic [numRows-1:0]         w_dp_nxt, w_dn_nxt;
    logic signed [DW-1:0]       w_delta [numCols];
    logic signed [accBits-1:0]  r_acc [numCols];
    logic                       r_in_ready, r_mac_en, r_out_valid, r_busy;
    logic [numRows-1:0]         r_dp, r_dn;

`ifdef QRACC_PLANE_SKIP_EN
    // Per plane: is the selected bit set on any row
    function automatic logic [xBits-1:0] plane_nz(input logic [numRows*xBits-1:0] x);
        plane_nz = '0;
        for (int r = 0; r < numRows; r++)
            for (int b = 0; b < xBits; b++)
                plane_nz[b] = plane_nz[b] | x[r*xBits + b];
    endfunction
    assign w_nz_in = plane_nz(in_data_i);
    assign w_nz_x  = plane_nz(r_x);
`else
    assign w_nz_in = '1;
    assign w_nz_x  = '1;
`endif

    // Lowest active plane in [start, n): {found, index}
    function automatic logic [NB:0] next_plane(input logic [xBits-1:0] nz, input int start,
                                               input logic [NB-1:0] n);
        next_plane = '0;
        for (int b = int'(xBits) - 1; b >= 0; b--)
            if (b >= start && b < int'(n) && nz[b]) next_plane = {1'b1, NB'(b)};
    endfunction

    assign w_n_cfg = (cfg_n_bits_i == '0 || cfg_n_bits_i > NB'(xBits)) ? NB'(xBits) : cfg_n_bits_i;
    assign w_first = next_plane(w_nz_in, 0, w_n_cfg);
    assign w_next  = next_plane(w_nz_x, int'(r_plane) + 1, r_n);

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_n_nxt     = r_n;
        w_plane_nxt = r_plane;
        w_cnt_nxt   = r_cnt;
        w_empty_nxt = r_empty;
        w_clear     = 1'b0;
        w_sample    = 1'b0;
        case (r_state)
            ST_IDLE: if (in_valid_i) begin
                w_state_nxt = ST_DRIVE;
                w_x_nxt     = in_data_i;
                w_n_nxt     = w_n_cfg;
                w_plane_nxt = w_first[NB-1:0];
                w_empty_nxt = ~w_first[NB];
                w_cnt_nxt   = '0;
                w_clear     = 1'b1;
            end
            ST_DRIVE: begin
                if (r_empty) begin
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == CW'(settleCycles - 1)) begin
                    w_sample  = 1'b1;
                    w_cnt_nxt = '0;
                    if (w_next[NB]) w_plane_nxt = w_next[NB-1:0];
                    else            w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            ST_DONE: if (out_ready_i) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Row drive for the upcoming cycle; the sign plane goes on the negative lines
    always_comb begin
        w_dp_nxt = '0;
        w_dn_nxt = '0;
        if (w_state_nxt == ST_DRIVE && !w_empty_nxt) begin
            for (int r = 0; r < numRows; r++) begin
                if (w_plane_nxt == w_n_nxt - NB'(1)) w_dn_nxt[r] = w_x_nxt[r*xBits + int'(w_plane_nxt)];
                else                                 w_dp_nxt[r] = w_x_nxt[r*xBits + int'(w_plane_nxt)];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < numCols; c++)
            w_delta[c] = $signed({1'b0, adc_out_i[c*numAdcBits +: numAdcBits]}) - $signed(DW'(MID));
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state     <= ST_IDLE;
            r_x         <= '0;
            r_n         <= '0;
            r_plane     <= '0;
            r_cnt       <= '0;
            r_empty     <= 1'b0;
            r_in_ready  <= 1'b1;
            r_mac_en    <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_dp        <= '0;
            r_dn        <= '0;
            for (int c = 0; c < numCols; c++) r_acc[c] <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_x         <= w_x_nxt;
            r_n         <= w_n_nxt;
            r_plane     <= w_plane_nxt;
            r_cnt       <= w_cnt_nxt;
            r_empty     <= w_empty_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_mac_en    <= (w_state_nxt == ST_DRIVE) && !w_empty_nxt;
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_dp        <= w_dp_nxt;
            r_dn        <= w_dn_nxt;
            for (int c = 0; c < numCols; c++) begin
                if (w_clear)       r_acc[c] <= '0;
                else if (w_sample) r_acc[c] <= r_acc[c] + (accBits'(w_delta[c]) <<< r_plane);
            end
        end
    end

    for (genvar c = 0; c < numCols; c++) begin : g_out
        assign out_data_o[c*accBits +: accBits] = r_acc[c];
    end

    assign in_ready_o  = r_in_ready;
    assign mac_en_o    = r_mac_en;
    assign out_valid_o = r_out_valid;
    assign busy_o      = r_busy;
    assign data_p_o    = r_dp;
    assign data_n_o    = r_dn;
endmodule

// File: tb/tb_qracc_bitserial_seq.sv
// Directed bench for qracc_bitserial_seq: one instance with settleCycles=2, one with 1.
module tb_qracc_bitserial_seq;
    localparam int NR = 128;
    localparam int NC = 8;
    localparam int XB = 4;
    localparam int AB = 4;
    localparam int ACC = AB + XB + 1;
`ifdef QRACC_PLANE_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              nrst;
    logic [2:0]        cfg;
    logic              in_valid;
    logic [NR*XB-1:0]  in_data;
    logic [NC*AB-1:0]  adc;
    logic              out_ready;

    logic              in_ready, mac_en, out_valid, busy;
    logic [NR-1:0]     dp, dn;
    logic [NC*ACC-1:0] out_data;
    logic              in_ready_s1, mac_en_s1, out_valid_s1, busy_s1;
    logic [NR-1:0]     dp_s1, dn_s1;
    logic [NC*ACC-1:0] out_data_s1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc, cyc2;

    always #5 clk = ~clk;

    qracc_bitserial_seq #(.settleCycles(2)) u_dut (
        .clk(clk), .nrst(nrst), .cfg_n_bits_i(cfg), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_data_i(in_data), .mac_en_o(mac_en), .data_p_o(dp), .data_n_o(dn), .adc_out_i(adc),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data), .busy_o(busy));

    qracc_bitserial_seq #(.settleCycles(1)) u_dut_s1 (
        .clk(clk), .nrst(nrst), .cfg_n_bits_i(cfg), .in_valid_i(in_valid), .in_ready_o(in_ready_s1),
        .in_data_i(in_data), .mac_en_o(mac_en_s1), .data_p_o(dp_s1), .data_n_o(dn_s1), .adc_out_i(adc),
        .out_valid_o(out_valid_s1), .out_ready_i(out_ready), .out_data_o(out_data_s1), .busy_o(busy_s1));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic logic [63:0] col(input logic [NC*ACC-1:0] d, input int c);
        logic signed [ACC-1:0] t;
        t = d[c*ACC +: ACC];
        return 64'(t);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input logic [XB-1:0] v);
        for (int r = 0; r < NR; r++) in_data[r*XB +: XB] = v;
    endtask

    task automatic set_adc(input logic [AB-1:0] v);
        for (int c = 0; c < NC; c++) adc[c*AB +: AB] = v;
    endtask

    task automatic accept(input int n, input logic [XB-1:0] xv);
        cfg = 3'(n);
        set_x(xv);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input bit s1, output int c);
        c = 0;
        while (!(s1 ? out_valid_s1 : out_valid) && c < 200) begin
            tick();
            c++;
        end
    endtask

    task automatic check_cols(input string tag, input bit s1, input int exp);
        for (int c = 0; c < NC; c++) chk(tag, col(s1 ? out_data_s1 : out_data, c), 64'(exp));
    endtask

    task automatic drain();
        int k = 0;
        out_ready = 1'b1;
        while (!(in_ready && in_ready_s1) && k < 50) begin
            tick();
            k++;
        end
        chk("drain_idle", 64'(in_ready & in_ready_s1), 64'(1));
        out_ready = 1'b0;
    endtask

    initial begin
        nrst = 1'b0; cfg = '0; in_valid = 1'b0; in_data = '0; adc = '0; out_ready = 1'b0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_mac_en", 64'(mac_en), 64'(0));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_drive", 64'(|dp | |dn), 64'(0));
        chk("rst_data", 64'(|out_data), 64'(0));
        @(negedge clk);
        nrst = 1'b1;
        tick();

        // n=2, x=+1, ADC 12 then 8 -> +4
        set_adc(4'd12);
        accept(2, 4'b0001);
        chk("t1_mac_en", 64'(mac_en), 64'(1));
        chk("t1_dp_p0", 64'(&dp), 64'(1));
        chk("t1_dn_p0", 64'(|dn), 64'(0));
        chk("t1_in_ready", 64'(in_ready), 64'(0));
        chk("t1_busy", 64'(busy), 64'(1));
        tick(); tick();
        set_adc(4'd8);
        chk("t1_dn_p1", 64'(|dn), 64'(0));
        wait_valid(1'b0, cyc);
        chk("t1_latency", 64'(cyc + 2), SKIP ? 64'(2) : 64'(4));
        check_cols("t1_sum", 1'b0, 4);
        drain();

        // n=2, x=-1, ADC 12 then 4 -> 4 - 8 = -4
        set_adc(4'd12);
        accept(2, 4'b1111);
        chk("t2_dp_p0", 64'(&dp), 64'(1));
        tick(); tick();
        set_adc(4'd4);
        chk("t2_dn_p1", 64'(&dn), 64'(1));
        chk("t2_dp_p1", 64'(|dp), 64'(0));
        wait_valid(1'b0, cyc);
        chk("t2_latency", 64'(cyc + 2), 64'(4));
        check_cols("t2_sum", 1'b0, -4);
        drain();

        // n=4, ADC constant 15 -> 7*15 = 105; latency 4 (settle 1) and 8 (settle 2)
        set_adc(4'd15);
        accept(4, 4'b1111);
        wait_valid(1'b1, cyc);
        chk("t3_latency_s1", 64'(cyc), 64'(4));
        check_cols("t3_sum_s1", 1'b1, 105);
        wait_valid(1'b0, cyc2);
        chk("t3_latency_s2", 64'(cyc + cyc2), 64'(8));
        check_cols("t3_sum_s2", 1'b0, 105);

        // Backpressure: result held, new vectors ignored
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            set_x(4'b0011);
            tick();
            chk("bp_in_ready", 64'(in_ready), 64'(0));
            chk("bp_out_valid", 64'(out_valid), 64'(1));
            chk("bp_col0", col(out_data, 0), 64'(105));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("bp_release_ready", 64'(in_ready), 64'(1));
        chk("bp_release_valid", 64'(out_valid), 64'(0));
        out_ready = 1'b0;
        drain();

        // n=1 sign plane only, ADC 4 -> -4
        set_adc(4'd4);
        accept(1, 4'b1111);
        chk("t4_dn", 64'(&dn), 64'(1));
        chk("t4_dp", 64'(|dp), 64'(0));
        wait_valid(1'b0, cyc);
        chk("t4_latency", 64'(cyc), 64'(2));
        check_cols("t4_sum", 1'b0, -4);
        drain();

        // cfg 0 clamps to 4 bits; ADC 9 -> 15
        set_adc(4'd9);
        accept(0, 4'b1111);
        wait_valid(1'b0, cyc);
        chk("t5_latency", 64'(cyc), 64'(8));
        check_cols("t5_sum", 1'b0, 15);
        drain();

        // Reset mid-DRIVE
        set_adc(4'd12);
        accept(4, 4'b1111);
        tick(); tick();
        #2 nrst = 1'b0;
        #1;
        chk("rd_mac_en", 64'(mac_en), 64'(0));
        chk("rd_drive", 64'(|dp | |dn), 64'(0));
        chk("rd_out_valid", 64'(out_valid), 64'(0));
        chk("rd_in_ready", 64'(in_ready), 64'(1));
        @(negedge clk);
        nrst = 1'b1;
        tick();
        set_adc(4'd8);
        accept(1, 4'b1111);
        chk("rd_accept_busy", 64'(busy), 64'(1));
        wait_valid(1'b0, cyc);
        chk("rd_latency", 64'(cyc), 64'(2));
        check_cols("rd_sum", 1'b0, 0);
        drain();

`ifdef QRACC_PLANE_SKIP_EN
        // Only plane 0 active: ADC 12 -> +4 after one settle period
        set_adc(4'd12);
        accept(4, 4'b0001);
        chk("sk_dp", 64'(&dp), 64'(1));
        wait_valid(1'b0, cyc);
        chk("sk_latency", 64'(cyc), 64'(2));
        check_cols("sk_sum", 1'b0, 4);
        drain();
        // All-zero vector: result 0 one cycle after accept
        accept(4, 4'b0000);
        chk("sk0_mac_en", 64'(mac_en), 64'(0));
        wait_valid(1'b0, cyc);
        chk("sk0_latency", 64'(cyc), 64'(1));
        check_cols("sk0_sum", 1'b0, 0);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
